// File: rtl/pid_chn_scheduler.sv
// rtl/pid_chn_scheduler.sv - frame scheduler feeding one shared, time-multiplexed PID core
// Optional macro PID_SCHED_RR_EN: rotate the per-frame start channel round-robin.
module pid_chn_scheduler #(
   parameter int NUM_CHN     = 4,
   parameter int CHN_WIDTH   = 3,
   parameter int DATA_WIDTH  = 16,
   parameter int CLK_FREQ    = 27_000_000,
   parameter int PID_FREQ    = 800,
   parameter int RES_TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_CHN-1:0]            chn_en,
   input  logic [NUM_CHN-1:0]            rpm_ready,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data,
   input  logic                          tr_valid,
   input  logic [CHN_WIDTH-1:0]          tr_chn,
   input  logic [DATA_WIDTH-1:0]         tr_data,
   input  logic                          tready,
   input  logic                          res_valid,
   input  logic [CHN_WIDTH-1:0]          res_chn,
   output logic                          data_valid,
   output logic [CHN_WIDTH-1:0]          data_chn,
   output logic [DATA_WIDTH-1:0]         data_fdb,
   output logic [DATA_WIDTH-1:0]         data_ref,
   output logic                          busy,
   output logic                          overrun,
   output logic                          timeout_err,
   output logic [7:0]                    overrun_cnt
);
   localparam int TICK_DIV = CLK_FREQ / PID_FREQ;
   localparam int TCW      = $clog2(TICK_DIV + 1);
   localparam int RCW      = $clog2(RES_TIMEOUT + 1);
   localparam int IW       = CHN_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, SELECT, ISSUE, WAIT_RES} state_t;

   state_t                 state_q, state_d;
   logic [TCW-1:0]         tick_cnt_q, tick_cnt_d;
   logic [DATA_WIDTH-1:0]  rpm_q [NUM_CHN];
   logic [DATA_WIDTH-1:0]  rpm_d [NUM_CHN];
   logic [DATA_WIDTH-1:0]  tgt_q [NUM_CHN];
   logic [DATA_WIDTH-1:0]  tgt_d [NUM_CHN];
   logic [NUM_CHN-1:0]     pending_q, pending_d;
   logic [RCW-1:0]         tmo_q, tmo_d;
   logic                   data_valid_q, data_valid_d;
   logic [CHN_WIDTH-1:0]   data_chn_q, data_chn_d;
   logic [DATA_WIDTH-1:0]  data_fdb_q, data_fdb_d;
   logic [DATA_WIDTH-1:0]  data_ref_q, data_ref_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;
   logic                   timeout_err_q, timeout_err_d;
   logic [7:0]             overrun_cnt_q, overrun_cnt_d;

   logic                   tick;
   logic                   frame_start;
   logic [CHN_WIDTH-1:0]   base;
   logic [CHN_WIDTH-1:0]   sel;
   logic                   sel_hit;
   logic [IW-1:0]          rot_idx;
   logic [DATA_WIDTH-1:0]  sel_fdb, sel_ref;
   logic                   res_hit, expired;

   assign tick        = (tick_cnt_q == TCW'(TICK_DIV - 1));
   assign tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
   assign frame_start = (state_q == IDLE) && tick && (chn_en != '0);

   always_comb begin
      for (int i = 0; i < NUM_CHN; i++) begin
         rpm_d[i] = rpm_ready[i] ? rpm_data[i*DATA_WIDTH +: DATA_WIDTH] : rpm_q[i];
         tgt_d[i] = (tr_valid && tr_chn == CHN_WIDTH'(i)) ? tr_data : tgt_q[i];
      end
   end

`ifdef PID_SCHED_RR_EN
   logic [CHN_WIDTH-1:0] base_q, base_d, next_base_q, next_base_d;

   always_comb begin
      base_d      = base_q;
      next_base_d = next_base_q;
      if (frame_start) begin
         base_d      = next_base_q;
         next_base_d = (next_base_q == CHN_WIDTH'(NUM_CHN - 1)) ? '0 : next_base_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         base_q      <= '0;
         next_base_q <= '0;
      end else begin
         base_q      <= base_d;
         next_base_q <= next_base_d;
      end
   end

   assign base = base_q;
`else
   assign base = '0;
`endif

   // First pending channel at or after base, wrapping modulo NUM_CHN.
   always_comb begin
      sel     = '0;
      sel_hit = 1'b0;
      rot_idx = '0;
      for (int k = 0; k < NUM_CHN; k++) begin
         rot_idx = {1'b0, base} + IW'(k);
         if (rot_idx >= IW'(NUM_CHN)) rot_idx = rot_idx - IW'(NUM_CHN);
         for (int j = 0; j < NUM_CHN; j++) begin
            if (!sel_hit && pending_q[j] && rot_idx == IW'(j)) begin
               sel     = CHN_WIDTH'(j);
               sel_hit = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel_fdb = '0;
      sel_ref = '0;
      for (int i = 0; i < NUM_CHN; i++) begin
         if (sel == CHN_WIDTH'(i)) begin
            sel_fdb = rpm_q[i];
            sel_ref = tgt_q[i];
         end
      end
   end

   assign res_hit = res_valid && (res_chn == data_chn_q);
   assign expired = (tmo_q == RCW'(RES_TIMEOUT - 1));

   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      tmo_d         = tmo_q;
      data_valid_d  = data_valid_q;
      data_chn_d    = data_chn_q;
      data_fdb_d    = data_fdb_q;
      data_ref_d    = data_ref_q;
      busy_d        = busy_q;
      overrun_d     = overrun_q;
      timeout_err_d = timeout_err_q;
      overrun_cnt_d = overrun_cnt_q;

      // Any tick outside IDLE is dropped, including the cycle WAIT_RES hands back to IDLE.
      if (tick && state_q != IDLE) begin
         overrun_d = 1'b1;
         if (overrun_cnt_q != 8'hFF) overrun_cnt_d = overrun_cnt_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            if (tick) pending_d = chn_en;
            if (frame_start) begin
               state_d = SELECT;
               busy_d  = 1'b1;
            end
         end
         SELECT: begin
            data_chn_d   = sel;
            data_fdb_d   = sel_fdb;
            data_ref_d   = sel_ref;
            data_valid_d = 1'b1;
            state_d      = ISSUE;
         end
         ISSUE: begin
            if (data_valid_q && tready) begin
               data_valid_d = 1'b0;
               tmo_d        = '0;
               state_d      = WAIT_RES;
               for (int i = 0; i < NUM_CHN; i++) begin
                  if (data_chn_q == CHN_WIDTH'(i)) pending_d[i] = 1'b0;
               end
            end
         end
         WAIT_RES: begin
            if (res_hit || expired) begin
               if (!res_hit) timeout_err_d = 1'b1;
               if (pending_q != '0) begin
                  state_d = SELECT;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         tick_cnt_q    <= '0;
         pending_q     <= '0;
         tmo_q         <= '0;
         data_valid_q  <= 1'b0;
         data_chn_q    <= '0;
         data_fdb_q    <= '0;
         data_ref_q    <= '0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_cnt_q <= '0;
         for (int i = 0; i < NUM_CHN; i++) begin
            rpm_q[i] <= '0;
            tgt_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         pending_q     <= pending_d;
         tmo_q         <= tmo_d;
         data_valid_q  <= data_valid_d;
         data_chn_q    <= data_chn_d;
         data_fdb_q    <= data_fdb_d;
         data_ref_q    <= data_ref_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
         overrun_cnt_q <= overrun_cnt_d;
         for (int i = 0; i < NUM_CHN; i++) begin
            rpm_q[i] <= rpm_d[i];
            tgt_q[i] <= tgt_d[i];
         end
      end
   end

   assign data_valid  = data_valid_q;
   assign data_chn    = data_chn_q;
   assign data_fdb    = data_fdb_q;
   assign data_ref    = data_ref_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_err_q;
   assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_pid_chn_scheduler.sv
// tb/tb_pid_chn_scheduler.sv - randomized bench for pid_chn_scheduler against a frame-level model
module tb_pid_chn_scheduler;
   localparam int NCH  = 4;
   localparam int CW   = 3;
   localparam int DW   = 16;
   localparam int CLKF = 100;
   localparam int PIDF = 1;
   localparam int TD   = CLKF / PIDF;
   localparam int RT   = 60;

   logic              clk = 1'b0;
   logic              rstn;
   logic [NCH-1:0]    chn_en, rpm_ready;
   logic [NCH*DW-1:0] rpm_data;
   logic              tr_valid;
   logic [CW-1:0]     tr_chn;
   logic [DW-1:0]     tr_data;
   logic              tready, res_valid;
   logic [CW-1:0]     res_chn;
   logic              data_valid;
   logic [CW-1:0]     data_chn;
   logic [DW-1:0]     data_fdb, data_ref;
   logic              busy, overrun, timeout_err;
   logic [7:0]        overrun_cnt;

   int n_checks = 0;
   int n_err    = 0;

   int             resp_dly  = 3;
   logic [NCH-1:0] skip_mask = '0;
   bit             noise_en  = 1'b0;

   typedef struct {int chn; int fdb; int rf;} hs_t;
   hs_t hs_log[$];

   always #5 clk = ~clk;

   pid_chn_scheduler #(
      .NUM_CHN(NCH), .CHN_WIDTH(CW), .DATA_WIDTH(DW),
      .CLK_FREQ(CLKF), .PID_FREQ(PIDF), .RES_TIMEOUT(RT)
   ) dut (
      .clk(clk), .rstn(rstn), .chn_en(chn_en), .rpm_ready(rpm_ready), .rpm_data(rpm_data),
      .tr_valid(tr_valid), .tr_chn(tr_chn), .tr_data(tr_data), .tready(tready),
      .res_valid(res_valid), .res_chn(res_chn), .data_valid(data_valid), .data_chn(data_chn),
      .data_fdb(data_fdb), .data_ref(data_ref), .busy(busy), .overrun(overrun),
      .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame-level model: a frame is a list of channels, each issued, handshaken, then awaited.
   int  m_cyc, m_wait, m_chn, m_fdb, m_ref, m_ocnt, m_frames;
   bit  m_busy, m_sel, m_valid, m_ovr, m_terr;
   int  m_rpm [NCH];
   int  m_tgt [NCH];
   int  m_q[$];

   task automatic model_reset();
      m_cyc = 0; m_wait = -1; m_chn = 0; m_fdb = 0; m_ref = 0; m_ocnt = 0; m_frames = 0;
      m_busy = 0; m_sel = 0; m_valid = 0; m_ovr = 0; m_terr = 0;
      m_q.delete();
      for (int i = 0; i < NCH; i++) begin m_rpm[i] = 0; m_tgt[i] = 0; end
   endtask

   task automatic model_step();
      bit tick, was_busy, hit;
      int start;
      tick     = (m_cyc == TD - 1);
      m_cyc    = tick ? 0 : m_cyc + 1;
      was_busy = m_busy;
      if (m_sel) begin
         m_chn   = m_q.pop_front();
         m_fdb   = m_rpm[m_chn];
         m_ref   = m_tgt[m_chn];
         m_valid = 1;
         m_sel   = 0;
      end else if (m_valid) begin
         if (tready) begin m_valid = 0; m_wait = 0; end
      end else if (m_wait >= 0) begin
         hit = res_valid && (int'(res_chn) == m_chn);
         if (hit || m_wait == RT - 1) begin
            if (!hit) m_terr = 1;
            m_wait = -1;
            if (m_q.size() > 0) m_sel = 1;
            else m_busy = 0;
         end else begin
            m_wait++;
         end
      end
      if (tick) begin
         if (was_busy) begin
            m_ovr = 1;
            if (m_ocnt < 255) m_ocnt++;
         end else if (chn_en != '0) begin
`ifdef PID_SCHED_RR_EN
            start = m_frames % NCH;
`else
            start = 0;
`endif
            m_frames++;
            m_q.delete();
            for (int k = 0; k < NCH; k++)
               if (chn_en[(start + k) % NCH]) m_q.push_back((start + k) % NCH);
            m_busy = 1;
            m_sel  = 1;
         end
      end
      for (int i = 0; i < NCH; i++)
         if (rpm_ready[i]) m_rpm[i] = int'(rpm_data[i*DW +: DW]);
      if (tr_valid && int'(tr_chn) < NCH) m_tgt[tr_chn[1:0]] = int'(tr_data);
   endtask

   initial model_reset();

   always @(posedge clk or negedge rstn) begin
      if (!rstn) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      check("cmp_data_valid", data_valid, m_valid);
      check("cmp_data_chn", data_chn, m_chn);
      check("cmp_data_fdb", data_fdb, m_fdb);
      check("cmp_data_ref", data_ref, m_ref);
      check("cmp_busy", busy, m_busy);
      check("cmp_overrun", overrun, m_ovr);
      check("cmp_timeout_err", timeout_err, m_terr);
      check("cmp_overrun_cnt", overrun_cnt, m_ocnt);
      if (rstn && data_valid && tready)
         hs_log.push_back('{int'(data_chn), int'(data_fdb), int'(data_ref)});
   end

   // PID core stand-in: answers resp_dly cycles after each handshake, optionally with noise.
   initial begin : responder
      logic [CW-1:0] ch;
      int d;
      res_valid = 1'b0;
      res_chn   = '0;
      forever begin
         @(negedge clk);
         if (rstn && data_valid && tready && !skip_mask[data_chn[1:0]]) begin
            ch = data_chn;
            d  = resp_dly;
            for (int k = 0; k < d; k++) begin
               @(posedge clk); #1;
               if (k == d - 1) begin
                  res_valid = 1'b1; res_chn = ch;
               end else if (noise_en && $urandom_range(1, 0) == 1) begin
                  res_valid = 1'b1; res_chn = ch + CW'($urandom_range(7, 1));
               end else begin
                  res_valid = 1'b0;
               end
            end
            @(posedge clk); #1;
            res_valid = 1'b0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step(2);
      rstn = 1'b1;
   endtask

   task automatic load_holds();
      for (int i = 0; i < NCH; i++) begin
         rpm_data[i*DW +: DW] = DW'(100 * (i + 1));
         rpm_ready    = '0;
         rpm_ready[i] = 1'b1;
         tr_valid     = 1'b1;
         tr_chn       = CW'(i);
         tr_data      = DW'(500 + 100 * i);
         step(1);
      end
      rpm_ready = '0;
      tr_valid  = 1'b0;
   endtask

   task automatic wait_frame(input int bound, input string nm);
      int n;
      n = 0;
      while (!busy && n < bound) begin step(1); n++; end
      while (busy && n < bound) begin step(1); n++; end
      n_checks++;
      if (n >= bound) begin
         n_err++;
         $display("FAIL %s: frame still open after %0d cycles, busy=%0b required 0", nm, bound, busy);
      end
   endtask

   task automatic check_hs(input string nm, input int idx, input int ch);
      if (idx >= hs_log.size()) begin
         check({nm, "_count"}, hs_log.size(), idx + 1);
      end else begin
         check({nm, "_chn"}, hs_log[idx].chn, ch);
         check({nm, "_fdb"}, hs_log[idx].fdb, 100 * (ch + 1));
         check({nm, "_ref"}, hs_log[idx].rf, 500 + 100 * ch);
      end
   endtask

   initial begin : watchdog
      #(10 * 80000);
      n_err++;
      $display("FAIL watchdog: run exceeded 80000 cycles, required completion");
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin : main
      int n;
      rstn = 1'b0; chn_en = '0; rpm_ready = '0; rpm_data = '0;
      tr_valid = 1'b0; tr_chn = '0; tr_data = '0; tready = 1'b1;
      step(2);
      check("rst_data_valid", data_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun_cnt", overrun_cnt, 0);
      check("rst_data_fdb", data_fdb, 0);
      rstn = 1'b1;

      // Full mask, ascending issue order.
      load_holds();
      chn_en = 4'b1111;
      hs_log.delete();
      wait_frame(300, "s1");
      check("s1_hs_count", hs_log.size(), 4);
      for (int i = 0; i < 4; i++) check_hs("s1", i, i);

      // Sparse mask.
      chn_en = 4'b1010;
      hs_log.delete();
      wait_frame(300, "s2");
      check("s2_hs_count", hs_log.size(), 2);
      check_hs("s2a", 0, 1);
      check_hs("s2b", 1, 3);

      // Backpressure in ISSUE.
      do_reset();
      load_holds();
      chn_en = 4'b1111;
      tready = 1'b0;
      hs_log.delete();
      n = 0;
      while (!data_valid && n < 300) begin step(1); n++; end
      check("s3_valid_seen", data_valid, 1);
      repeat (10) begin
         check("s3_hold_valid", data_valid, 1);
         check("s3_hold_chn", data_chn, 0);
         check("s3_hold_fdb", data_fdb, 100);
         check("s3_hold_ref", data_ref, 500);
         step(1);
      end
      check("s3_no_hs_yet", hs_log.size(), 0);
      tready = 1'b1;
      wait_frame(300, "s3");
      check("s3_hs_count", hs_log.size(), 4);
      check_hs("s3", 0, 0);

      // Result timeout on ch0.
      do_reset();
      load_holds();
      skip_mask = 4'b0001;
      check("s4_terr_before", timeout_err, 0);
      hs_log.delete();
      wait_frame(400, "s4");
      check("s4_terr_after", timeout_err, 1);
      check("s4_hs_count", hs_log.size(), 4);
      for (int i = 0; i < 4; i++) check_hs("s4", i, i);

      // Every result withheld: frame spans three ticks.
      do_reset();
      load_holds();
      skip_mask = 4'b1111;
      wait_frame(600, "s5");
      check("s5_overrun", overrun, 1);
      check("s5_overrun_cnt", overrun_cnt, 2);

      // Async reset while waiting for a result.
      n = 0;
      while (!data_valid && n < 300) begin step(1); n++; end
      while (data_valid && n < 300) begin step(1); n++; end
      check("s6_in_wait", busy, 1);
      step(5);
      rstn = 1'b0;
      #1;
      check("s6_rst_valid", data_valid, 0);
      check("s6_rst_busy", busy, 0);
      check("s6_rst_overrun", overrun, 0);
      check("s6_rst_ocnt", overrun_cnt, 0);
      check("s6_rst_terr", timeout_err, 0);
      check("s6_rst_chn", data_chn, 0);
      step(1);
      rstn = 1'b1;
      skip_mask = '0;
      load_holds();
      hs_log.delete();
      wait_frame(300, "s6");
      check("s6_hs_count", hs_log.size(), 4);
      check_hs("s6", 0, 0);

`ifdef PID_SCHED_RR_EN
      do_reset();
      load_holds();
      for (int f = 0; f < 5; f++) begin
         hs_log.delete();
         wait_frame(300, "rr");
         check_hs("rr_first", 0, f % NCH);
      end
`endif

      // Overrun counter saturation.
      tready = 1'b0;
      step(302 * TD);
      check("s7_ocnt_sat", overrun_cnt, 255);
      check("s7_overrun", overrun, 1);
      tready = 1'b1;
      wait_frame(400, "s7");

      // Randomized traffic.
      noise_en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(49, 0) == 0) chn_en = NCH'($urandom);
         tready    = ($urandom_range(3, 0) != 0);
         rpm_ready = NCH'($urandom) & NCH'($urandom);
         for (int i = 0; i < NCH; i++) rpm_data[i*DW +: DW] = DW'($urandom);
         tr_valid  = ($urandom_range(3, 0) == 0);
         tr_chn    = CW'($urandom);
         tr_data   = DW'($urandom);
         if ($urandom_range(99, 0) == 0)
            resp_dly = ($urandom_range(9, 0) == 0) ? RT + 10 : int'($urandom_range(8, 1));
         if ($urandom_range(199, 0) == 0)
            skip_mask = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
         if (c == 2000) rstn = 1'b0;
         if (c == 2003) rstn = 1'b1;
         step(1);
      end
      noise_en = 1'b0; skip_mask = '0; tready = 1'b1; rpm_ready = '0; tr_valid = 1'b0;
      step(10);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/pid_chn_scheduler.md
Name: pid_chn_scheduler

Overview:
Frame scheduler for the shared, time-multiplexed PID core. A PID-rate tick starts each frame. For every enabled channel the block issues one feedback/reference sample to the core, then waits for that channel's result before issuing the next. It holds the latest measured rpm and target rpm per channel and flags frames that overrun the PID period.

Parameters:
- NUM_CHN, 4, number of motor channels (1..4)
- CHN_WIDTH, 3, channel index width
- DATA_WIDTH, 16, rpm / target sample width
- CLK_FREQ, 27_000_000, clk frequency in Hz
- PID_FREQ, 800, frame rate in Hz; tick period TICK_DIV = CLK_FREQ/PID_FREQ cycles
- RES_TIMEOUT, 255, max cycles to wait for a core result

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- chn_en  in  NUM_CHN  per-channel enable mask
- rpm_ready  in  NUM_CHN  per-channel measured-rpm strobe
- rpm_data  in  NUM_CHN*DATA_WIDTH  measured rpm; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- tr_valid  in  1  target-rpm write strobe
- tr_chn  in  CHN_WIDTH  target channel index
- tr_data  in  DATA_WIDTH  target rpm
- tready  in  1  PID core can accept a sample
- res_valid  in  1  PID core result strobe
- res_chn  in  CHN_WIDTH  channel of the result
- data_valid  out  1  sample valid to core
- data_chn  out  CHN_WIDTH  sample channel
- data_fdb  out  DATA_WIDTH  feedback (held rpm)
- data_ref  out  DATA_WIDTH  reference (held target)
- busy  out  1  frame in progress
- overrun  out  1  sticky; tick arrived while busy
- timeout_err  out  1  sticky; result wait expired
- overrun_cnt  out  8  saturating count of dropped ticks

Behaviour:
- Reset (async, rstn low):
  - all outputs 0
  - held rpm and targets 0
  - tick counter 0
  - FSM IDLE
  - an in-flight frame is abandoned immediately
- Sample and hold:
  - rpm_ready[i] loads channel i's rpm into hold register i
  - tr_valid with tr_chn < NUM_CHN loads target tr_chn; tr_chn >= NUM_CHN is ignored
- Tick:
  - counter runs 0..TICK_DIV-1 continuously from reset
  - tick is a 1-cycle pulse when the counter wraps
- FSM states: IDLE, SELECT, ISSUE, WAIT_RES.
  - IDLE: on tick, pending <= chn_en. If chn_en == 0, stay IDLE. Otherwise go SELECT; busy=1.
  - SELECT (1 cycle):
    - sel = first set bit of pending, searching upward from the start index (0 unless the optional feature is enabled)
    - register data_chn = sel, data_fdb = held rpm[sel], data_ref = target[sel]; these are snapshot values
    - data_valid <= 1; go ISSUE
  - ISSUE:
    - hold data_valid and data_* stable until data_valid && tready; handshake completes on that edge
    - next cycle: data_valid=0, clear pending[sel], load timeout counter, go WAIT_RES
  - WAIT_RES:
    - res_valid && res_chn == sel: go SELECT if pending != 0, else IDLE with busy=0
    - res_valid for any other channel is ignored
    - counter reaches RES_TIMEOUT: set timeout_err, then continue exactly as if the result had arrived
- Tick while not IDLE: tick dropped; overrun <= 1; overrun_cnt increments, saturating at 255.
- Tick on the same cycle WAIT_RES returns to IDLE: treated as busy and dropped. The next tick starts the frame.
- chn_en changes mid-frame: no effect until the next frame.
- Latency: tick to first data_valid is 2 cycles (IDLE to SELECT to ISSUE).
- Sticky flags clear only on reset.

Optional Feature:
- Macro: PID_SCHED_RR_EN
- Defined: the start index rotates by +1 modulo NUM_CHN at each frame start, so core-issue order is round-robin across frames.
- Undefined: the start index is always 0 and order is always ascending channel index.

Test Plan:
- Reset, chn_en=4'b1111, rpm0..3 = 100/200/300/400, targets = 500/600/700/800, tready=1, result returned 3 cycles after each handshake -> per tick, exactly 4 handshakes in order ch0..ch3 with fdb/ref pairs (100,500)..(400,800); busy drops after the ch3 result.
- chn_en=4'b1010 -> only ch1 then ch3 issued; ch0/ch2 never appear on data_chn.
- tready held low 10 cycles in ISSUE -> data_valid and data_* stable for those 10 cycles; single handshake when tready rises.
- No res_valid for ch0 -> timeout_err=1 after RES_TIMEOUT cycles; ch1 issued next cycle after timeout.
- Results withheld so a frame spans 3 ticks -> overrun=1, overrun_cnt=2; next frame starts on the first tick after idle. Force 300 overruns -> overrun_cnt holds 255.
- rstn asserted during WAIT_RES -> all outputs 0 immediately; after release the first tick restarts at ch0. With PID_SCHED_RR_EN, consecutive frames start at ch0, ch1, ch2, ch3, ch0.
